counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Sequencing controller for the 4-bit up/down counting datapath on the divided clock. It latches a programmed window [lo, hi] and runs the counter through that window, either as a single sweep or as a bounded or unbounded ping-pong. Start, pause and stop commands come from the debounced button logic. Count, direction, busy and done drive the 7-segment/LED display layer.

## Interface
Parameters:
- WIDTH, 4, counter and bound width
- LAPW, 4, width of the lap limit and lap counter

Ports:
- clock_div  in  1  divided system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- start  in  1  one-cycle synchronous pulse; begins a run from IDLE
- pause  in  1  one-cycle pulse; toggles RUN and HOLD
- stop  in  1  one-cycle pulse; aborts to IDLE
- mode  in  1  0 = single sweep, 1 = ping-pong; sampled at start
- dir  in  1  initial direction, 1 = up, 0 = down; sampled at start
- lo  in  WIDTH  lower bound; sampled at start
- hi  in  WIDTH  upper bound; sampled at start
- laps  in  LAPW  ping-pong endpoint-arrival limit; 0 = run forever; sampled at start
- count  out  WIDTH  current counter value
- up_down  out  1  current direction, 1 = up
- busy  out  1  high in RUN or HOLD
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States are IDLE, RUN and HOLD.
- Reset values: state IDLE, count 0, up_down 1, busy 0, done 0, err 0, lap counter 0, latched bounds 0.
- Command priority: stop > pause > start.

IDLE
- On start with lo < hi: latch lo, hi, mode, laps; load count with lo if dir = 1, else hi; set up_down = dir; clear the lap counter; go to RUN.
- On start with lo >= hi: pulse err, stay in IDLE, leave count unchanged.
- pause and stop have no effect.

RUN, each edge
- stop: go to IDLE; count holds; no done pulse.
- pause: go to HOLD; count holds this edge.
- Otherwise, if count is at the endpoint for the current direction (hi when up, lo when down), this edge is an arrival:
  - Single mode: go to IDLE, pulse done, count holds.
  - Ping-pong mode: increment the lap counter. If laps != 0 and the incremented value equals laps, go to IDLE, pulse done, count holds. Otherwise invert up_down and step count one place in the new direction on this same edge. The count never dwells at an endpoint.
- Otherwise step count by +1 or -1 according to up_down.
- start is ignored.

HOLD
- stop: go to IDLE.
- pause: go to RUN.
- start is ignored. count and up_down hold.

General rules
- Changes to lo, hi, mode, dir or laps during RUN or HOLD have no effect until the next start.
- Arithmetic is modulo 2^WIDTH, but the bound check guarantees count stays inside [lo, hi], so wrap-around never occurs.
- Ping-pong with laps = 1 behaves exactly like single mode.

## Timing
- Start latency: start high before edge k gives count = start value and busy = 1 after edge k.
- The first step occurs at edge k+1.
- The endpoint value is visible for exactly one cycle while in RUN.
- done and err are registered. Each is high for exactly one cycle after the deciding edge. On completion, done coincides with the first IDLE cycle.
- An arrival edge coinciding with pause: pause wins. count holds at the endpoint and the arrival is re-evaluated on the first RUN edge after resume.
- An arrival edge coinciding with stop: stop wins and done stays 0.
- Asserting reset during RUN or HOLD clears everything immediately, without waiting for a clock edge. The first edge after release sees IDLE.
- A single run stays busy for hi - lo + 1 cycles.

## Structure
- Shared package counter_seq_pkg holds:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0
  - MODE_SINGLE = 1'b0, MODE_PINGPONG = 1'b1
- Sub-module updown_counter_en: loadable WIDTH-bit up/down counter with ports clock_div, reset, load, load_val, en, up_down, count.
- The FSM, bound latches and lap counter live in counter_sequencer.

## Test plan
- Single sweep up: lo = 2, hi = 5, dir = 1, mode = 0, start pulse -> count 2,3,4,5 on successive cycles; busy high for 4 cycles; done one cycle; count holds at 5.
- Ping-pong bounded: lo = 1, hi = 3, dir = 1, laps = 3 -> count 1,2,3,2,1,2,3; done after the third arrival; up_down drops when leaving 3 and rises when leaving 1.
- Rejected start: lo = 7, hi = 7 -> err one cycle; busy stays 0; count unchanged.
- Pause and stop: pause pulse at count = 4 during an up sweep to 9 -> count holds at 4 through HOLD and resumes 5 after a second pause; a later stop at count 6 -> IDLE, count stays 6, done = 0.
- Reset and collisions: reset low mid-RUN -> count 0 and up_down 1 asynchronously; pause and stop asserted on the same edge in RUN -> IDLE; start during HOLD -> ignored.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer and its display-facing bus.
package counter_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic DIR_UP        = 1'b1;
   localparam logic DIR_DOWN      = 1'b0;
   localparam logic MODE_SINGLE   = 1'b0;
   localparam logic MODE_PINGPONG = 1'b1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command/program inputs and display-facing status of the counter sequencer.
interface counter_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int LAPW  = 4
);
   logic             start;
   logic             pause;
   logic             stop;
   logic             mode;
   logic             dir;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [LAPW-1:0]  laps;
   logic [WIDTH-1:0] count;
   logic             up_down;
   logic             busy;
   logic             done;
   logic             err;

   // Command source / display consumer side.
   modport master (
      output start, pause, stop, mode, dir, lo, hi, laps,
      input  count, up_down, busy, done, err
   );

   // Sequencer side.
   modport slave (
      input  start, pause, stop, mode, dir, lo, hi, laps,
      output count, up_down, busy, done, err
   );
endinterface

// File: rtl/updown_counter_en.sv
// Loadable up/down counter; load has priority over a count step.
module updown_counter_en #(
   parameter int WIDTH = 4
) (
   input  logic             clock_div,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_down,
   output logic [WIDTH-1:0] count
);

   // Load a new value, or step one place in the requested direction.
   always_ff @(posedge clock_div or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= up_down ? count + 1'b1 : count - 1'b1;
   end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer: latches a [lo, hi] window at start and drives the counter
// through it as a single sweep or a bounded/unbounded ping-pong.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LAPW  = 4
) (
   input logic                 clock_div,
   input logic                 reset,
   counter_sequencer_if.slave  bus
);

   state_t           state;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic             mode_q;
   logic [LAPW-1:0]  laps_q, lap_q;
   logic             dir_q, busy_q, done_q, err_q;
   logic [WIDTH-1:0] count;

   logic             at_end, run_go, finish, start_ok;
   logic [LAPW-1:0]  lap_nxt;
   logic             cnt_load, cnt_en, cnt_dir;
   logic [WIDTH-1:0] cnt_val;

   // An arrival is the endpoint of the current direction; a ping-pong run
   // finishes when the arrival count reaches a non-zero lap limit.
   assign at_end   = (dir_q == DIR_UP) ? (count == hi_q) : (count == lo_q);
   assign lap_nxt  = lap_q + 1'b1;
   assign run_go   = (state == ST_RUN) && !bus.stop && !bus.pause;
   assign finish   = run_go && at_end &&
                     ((mode_q == MODE_SINGLE) || ((laps_q != '0) && (lap_nxt == laps_q)));
   assign start_ok = (state == ST_IDLE) && bus.start && (bus.lo < bus.hi);

   // Reversal steps in the new direction on the same edge, so the count
   // never dwells on an endpoint.
   assign cnt_load = start_ok;
   assign cnt_val  = (bus.dir == DIR_UP) ? bus.lo : bus.hi;
   assign cnt_en   = run_go && !finish;
   assign cnt_dir  = at_end ? ~dir_q : dir_q;

   updown_counter_en #(.WIDTH(WIDTH)) u_cnt (
      .clock_div (clock_div),
      .reset     (reset),
      .load      (cnt_load),
      .load_val  (cnt_val),
      .en        (cnt_en),
      .up_down   (cnt_dir),
      .count     (count)
   );

   // Control FSM with latched program, lap counter and registered status.
   always_ff @(posedge clock_div or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         lo_q   <= '0;
         hi_q   <= '0;
         mode_q <= MODE_SINGLE;
         laps_q <= '0;
         lap_q  <= '0;
         dir_q  <= DIR_UP;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  lo_q   <= bus.lo;
                  hi_q   <= bus.hi;
                  mode_q <= bus.mode;
                  laps_q <= bus.laps;
                  lap_q  <= '0;
                  dir_q  <= bus.dir;
                  busy_q <= 1'b1;
                  state  <= ST_RUN;
               end else if (bus.start) begin
                  err_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (bus.pause) begin
                  state <= ST_HOLD;
               end else if (finish) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else if (at_end) begin
                  // Only ping-pong gets here: single mode always finishes.
                  lap_q <= lap_nxt;
                  dir_q <= ~dir_q;
               end
            end
            ST_HOLD: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (bus.pause) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count   = count;
   assign bus.up_down = dir_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_counter_sequencer;

   logic clock_div;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 0;

   counter_sequencer_if #(.WIDTH(4), .LAPW(4)) bus ();

   counter_sequencer #(.WIDTH(4), .LAPW(4)) dut (
      .clock_div (clock_div),
      .reset     (reset),
      .bus       (bus)
   );

   initial clock_div = 1'b0;
   always #5 clock_div = ~clock_div;

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 running, 2 held
   int         m_phase = 0;
   logic [3:0] m_cnt = 4'd0, m_lo = 4'd0, m_hi = 4'd0, m_laps = 4'd0;
   bit         m_up = 1, m_mode = 0, m_done = 0, m_err = 0;
   int         m_arrivals = 0;

   initial begin
      forever begin
         @(posedge clock_div or negedge reset);
         if (!reset) begin
            m_phase = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_laps = 0;
            m_up = 1; m_mode = 0; m_done = 0; m_err = 0; m_arrivals = 0;
         end else begin
            m_done = 0;
            m_err  = 0;
            if (m_phase == 0) begin
               if (bus.start) begin
                  if (bus.lo < bus.hi) begin
                     m_lo = bus.lo; m_hi = bus.hi; m_mode = bus.mode; m_laps = bus.laps;
                     m_up = bus.dir;
                     m_cnt = bus.dir ? bus.lo : bus.hi;
                     m_arrivals = 0;
                     m_phase = 1;
                  end else begin
                     m_err = 1;
                  end
               end
            end else if (m_phase == 1) begin
               if (bus.stop) m_phase = 0;
               else if (bus.pause) m_phase = 2;
               else if (m_cnt == (m_up ? m_hi : m_lo)) begin
                  m_arrivals++;
                  if (!m_mode || (m_laps != 0 && m_arrivals == m_laps)) begin
                     m_phase = 0;
                     m_done  = 1;
                  end else begin
                     m_up  = !m_up;
                     m_cnt = m_up ? m_cnt + 4'd1 : m_cnt - 4'd1;
                  end
               end else begin
                  m_cnt = m_up ? m_cnt + 4'd1 : m_cnt - 4'd1;
               end
            end else begin
               if (bus.stop) m_phase = 0;
               else if (bus.pause) m_phase = 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clock_div);
         if (chk_en) begin
            chk("mdl_count",   32'(bus.count),   32'(m_cnt));
            chk("mdl_up_down", 32'(bus.up_down), 32'(m_up));
            chk("mdl_busy",    32'(bus.busy),    32'(m_phase != 0));
            chk("mdl_done",    32'(bus.done),    32'(m_done));
            chk("mdl_err",     32'(bus.err),     32'(m_err));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock_div);
      #1;
   endtask

   task automatic go(input logic [3:0] l, input logic [3:0] h, input logic d,
                     input logic m, input logic [3:0] lp);
      bus.lo = l; bus.hi = h; bus.dir = d; bus.mode = m; bus.laps = lp;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic do_pause();
      bus.pause = 1'b1; tick(); bus.pause = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
   endtask

   int pp_cnt[7] = '{1, 2, 3, 2, 1, 2, 3};
   int pp_dir[7] = '{1, 1, 1, 0, 0, 1, 1};

   initial begin
      reset = 1'b0;
      bus.start = 0; bus.pause = 0; bus.stop = 0; bus.mode = 0; bus.dir = 1;
      bus.lo = 0; bus.hi = 0; bus.laps = 0;
      repeat (2) @(posedge clock_div);
      #1;
      chk("rst_count",   32'(bus.count), 0);
      chk("rst_up_down", 32'(bus.up_down), 1);
      chk("rst_busy",    32'(bus.busy), 0);
      chk("rst_done",    32'(bus.done), 0);
      chk("rst_err",     32'(bus.err), 0);
      reset = 1'b1;
      chk_en = 1;
      tick();

      // Single sweep up 2..5
      go(2, 5, 1, 0, 0);
      for (int v = 2; v <= 5; v++) begin
         chk("single_count", 32'(bus.count), 32'(v));
         chk("single_busy",  32'(bus.busy), 1);
         if (v < 5) tick();
      end
      tick();
      chk("single_done",   32'(bus.done), 1);
      chk("single_idle",   32'(bus.busy), 0);
      chk("single_hold5",  32'(bus.count), 5);
      tick();
      chk("single_done_1cyc", 32'(bus.done), 0);

      // Ping-pong 1..3, three arrivals
      go(1, 3, 1, 1, 3);
      for (int i = 0; i < 7; i++) begin
         chk("pp_count", 32'(bus.count), 32'(pp_cnt[i]));
         chk("pp_dir",   32'(bus.up_down), 32'(pp_dir[i]));
         chk("pp_done0", 32'(bus.done), 0);
         tick();
      end
      chk("pp_done",  32'(bus.done), 1);
      chk("pp_idle",  32'(bus.busy), 0);
      chk("pp_end",   32'(bus.count), 3);

      // Rejected start (lo == hi)
      go(7, 7, 1, 0, 0);
      chk("rej_err",   32'(bus.err), 1);
      chk("rej_busy",  32'(bus.busy), 0);
      chk("rej_count", 32'(bus.count), 3);
      tick();
      chk("rej_err_1cyc", 32'(bus.err), 0);

      // Pause/resume, start ignored in HOLD, then stop
      go(2, 9, 1, 0, 0);
      tick(); tick();
      chk("ps_count4", 32'(bus.count), 4);
      do_pause();
      chk("hold_count", 32'(bus.count), 4);
      chk("hold_busy",  32'(bus.busy), 1);
      tick(); tick();
      chk("hold_still", 32'(bus.count), 4);
      go(0, 15, 0, 0, 0);
      chk("hold_start_ign", 32'(bus.count), 4);
      chk("hold_start_dir", 32'(bus.up_down), 1);
      do_pause();
      chk("resume_edge", 32'(bus.count), 4);
      tick();
      chk("resume_5", 32'(bus.count), 5);
      tick();
      chk("resume_6", 32'(bus.count), 6);
      do_stop();
      chk("stop_count", 32'(bus.count), 6);
      chk("stop_busy",  32'(bus.busy), 0);
      chk("stop_done",  32'(bus.done), 0);

      // pause and stop on the same edge: stop wins
      go(0, 8, 1, 0, 0);
      tick();
      bus.pause = 1; bus.stop = 1; tick(); bus.pause = 0; bus.stop = 0;
      chk("ps_collide_busy",  32'(bus.busy), 0);
      chk("ps_collide_count", 32'(bus.count), 1);

      // Arrival coinciding with pause: re-evaluated after resume
      go(3, 4, 1, 0, 0);
      tick();
      do_pause();
      chk("arr_pause_cnt",  32'(bus.count), 4);
      chk("arr_pause_done", 32'(bus.done), 0);
      do_pause();
      tick();
      chk("arr_resume_done", 32'(bus.done), 1);
      chk("arr_resume_cnt",  32'(bus.count), 4);

      // Down sweep in ping-pong with laps = 1 acts as single
      go(5, 8, 0, 1, 1);
      chk("down_start", 32'(bus.count), 8);
      chk("down_dir",   32'(bus.up_down), 0);
      tick(); tick(); tick();
      chk("down_lo", 32'(bus.count), 5);
      tick();
      chk("down_done", 32'(bus.done), 1);
      chk("down_end",  32'(bus.count), 5);

      // Asynchronous reset mid-run
      go(2, 12, 1, 1, 0);
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count), 0);
      chk("arst_dir",   32'(bus.up_down), 1);
      chk("arst_busy",  32'(bus.busy), 0);
      tick();
      #2 reset = 1'b1;
      tick();
      chk("arst_after", 32'(bus.busy), 0);

      // Randomized traffic checked by the model
      for (int c = 0; c < 2000; c++) begin
         bus.start = ($urandom_range(0, 5) == 0);
         bus.pause = ($urandom_range(0, 11) == 0);
         bus.stop  = ($urandom_range(0, 23) == 0);
         bus.lo    = 4'($urandom_range(0, 15));
         bus.hi    = 4'($urandom_range(0, 15));
         bus.dir   = 1'($urandom_range(0, 1));
         bus.mode  = 1'($urandom_range(0, 1));
         bus.laps  = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 299) == 0) begin
            #1 reset = 1'b0;
            #1 reset = 1'b1;
         end
         tick();
      end
      bus.start = 0; bus.pause = 0; bus.stop = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
